// File: rtl/ysyx_22050550_mmio_pkg.sv
// rtl/ysyx_22050550_mmio_pkg.sv - shared FSM states, AXI response codes and default MMIO base
package ysyx_22050550_mmio_pkg;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [63:0] MMIO_BASE = 64'ha000_0000;

endpackage

// File: rtl/ysyx_22050550_mmio_regfile.sv
// rtl/ysyx_22050550_mmio_regfile.sv - NREG x 64-bit register file
// One combinational read port and one byte-strobed write port.
module ysyx_22050550_mmio_regfile
  import ysyx_22050550_mmio_pkg::*;
#(
  parameter int NREG = 16,
  parameter int IW   = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx_i,
  output logic [63:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [63:0]   wr_data_i,
  input  logic [7:0]    wr_strb_i
);

  logic [63:0] regs_q [NREG];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int b = 0; b < 8; b++)
        if (wr_strb_i[b]) regs_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
    end
  end

  assign rd_data_o = regs_q[rd_idx_i];

endmodule

// File: rtl/ysyx_22050550_mmio_axi_slave.sv
// rtl/ysyx_22050550_mmio_axi_slave.sv - single-beat 64-bit AXI4 MMIO responder
// Optional MMIO_RESP_CHECK_EN: DECERR on miss, SLVERR on len/size violation.
module ysyx_22050550_mmio_axi_slave
  import ysyx_22050550_mmio_pkg::*;
#(
  parameter logic [63:0] BASE   = MMIO_BASE,
  parameter int          NREG   = 16,
  parameter int          RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ar_valid,
  output logic        io_ar_ready,
  input  logic [63:0] io_ar_addr,
  input  logic [7:0]  io_ar_len,
  input  logic [2:0]  io_ar_size,
  input  logic [1:0]  io_ar_burst,
  output logic        io_r_valid,
  input  logic        io_r_ready,
  output logic [63:0] io_r_rdata,
  output logic [1:0]  io_r_rresp,
  output logic        io_r_last,
  input  logic        io_aw_valid,
  output logic        io_aw_ready,
  input  logic [63:0] io_aw_addr,
  input  logic [7:0]  io_aw_len,
  input  logic [2:0]  io_aw_size,
  input  logic [1:0]  io_aw_burst,
  input  logic        io_w_valid,
  output logic        io_w_ready,
  input  logic [63:0] io_w_data,
  input  logic [7:0]  io_w_strb,
  input  logic        io_w_last,
  output logic        io_b_valid,
  input  logic        io_b_ready,
  output logic [1:0]  io_b_bresp
);

  localparam int          IW        = $clog2(NREG);
  localparam logic [63:0] SPAN      = 64'(NREG) * 64'd8;
  localparam logic [2:0]  RCNT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  function automatic logic addr_hit(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  function automatic logic [IW-1:0] addr_idx(input logic [63:0] a);
    return IW'((a - BASE) >> 3);
  endfunction

  rstate_e     rstate_q;
  logic [63:0] ar_addr_q;
  logic [7:0]  ar_len_q;
  logic [2:0]  ar_size_q;
  logic [2:0]  rcnt_q;
  logic        ar_ready_q, r_valid_q;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;

  wstate_e     wstate_q;
  logic [63:0] aw_addr_q;
  logic [7:0]  aw_len_q;
  logic [2:0]  aw_size_q;
  logic        aw_ready_q, w_ready_q, b_valid_q;
  logic [1:0]  bresp_q;

  logic [63:0] rd_addr, rf_rdata, rd_data_d;
  logic [7:0]  rd_len;
  logic [2:0]  rd_size;
  logic        rd_hit, wr_hit, wr_en;
  logic [1:0]  rd_resp, wr_resp;
  logic        unused_bits;

  // With zero latency the response is captured straight off the AR channel.
  assign rd_addr   = (rstate_q == R_IDLE) ? io_ar_addr : ar_addr_q;
  assign rd_len    = (rstate_q == R_IDLE) ? io_ar_len  : ar_len_q;
  assign rd_size   = (rstate_q == R_IDLE) ? io_ar_size : ar_size_q;
  assign rd_hit    = addr_hit(rd_addr);
  assign wr_hit    = addr_hit(aw_addr_q);
  assign rd_data_d = rd_hit ? rf_rdata : 64'd0;

`ifdef MMIO_RESP_CHECK_EN
  assign rd_resp = !rd_hit ? RESP_DECERR :
                   (rd_len != 8'd0 || rd_size != 3'd3) ? RESP_SLVERR : RESP_OKAY;
  assign wr_resp = !wr_hit ? RESP_DECERR :
                   (aw_len_q != 8'd0 || aw_size_q != 3'd3) ? RESP_SLVERR : RESP_OKAY;
  assign unused_bits = ^{io_ar_burst, io_aw_burst, io_w_last};
`else
  assign rd_resp = RESP_OKAY;
  assign wr_resp = RESP_OKAY;
  assign unused_bits = ^{io_ar_burst, io_aw_burst, io_w_last, rd_len, rd_size, aw_len_q, aw_size_q};
`endif

  assign wr_en = (wstate_q == W_DATA) && io_w_valid && wr_hit && (wr_resp == RESP_OKAY);

  ysyx_22050550_mmio_regfile #(.NREG(NREG), .IW(IW)) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .rd_idx_i  (addr_idx(rd_addr)),
    .rd_data_o (rf_rdata),
    .wr_en_i   (wr_en),
    .wr_idx_i  (addr_idx(aw_addr_q)),
    .wr_data_i (io_w_data),
    .wr_strb_i (io_w_strb)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate_q   <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      rcnt_q     <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: if (io_ar_valid) begin
          ar_addr_q  <= io_ar_addr;
          ar_len_q   <= io_ar_len;
          ar_size_q  <= io_ar_size;
          ar_ready_q <= 1'b0;
          if (RD_LAT == 0) begin
            rstate_q  <= R_RESP;
            r_valid_q <= 1'b1;
            rdata_q   <= rd_data_d;
            rresp_q   <= rd_resp;
          end else begin
            rstate_q <= R_WAIT;
            rcnt_q   <= RCNT_INIT;
          end
        end
        R_WAIT: if (rcnt_q == 3'd0) begin
          rstate_q  <= R_RESP;
          r_valid_q <= 1'b1;
          rdata_q   <= rd_data_d;
          rresp_q   <= rd_resp;
        end else begin
          rcnt_q <= rcnt_q - 3'd1;
        end
        R_RESP: if (io_r_ready) begin
          rstate_q   <= R_IDLE;
          r_valid_q  <= 1'b0;
          ar_ready_q <= 1'b1;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wstate_q   <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: if (io_aw_valid) begin
          wstate_q   <= W_DATA;
          aw_addr_q  <= io_aw_addr;
          aw_len_q   <= io_aw_len;
          aw_size_q  <= io_aw_size;
          aw_ready_q <= 1'b0;
          w_ready_q  <= 1'b1;
        end
        W_DATA: if (io_w_valid) begin
          wstate_q  <= W_RESP;
          w_ready_q <= 1'b0;
          b_valid_q <= 1'b1;
          bresp_q   <= wr_resp;
        end
        W_RESP: if (io_b_ready) begin
          wstate_q   <= W_IDLE;
          b_valid_q  <= 1'b0;
          aw_ready_q <= 1'b1;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  assign io_ar_ready = ar_ready_q;
  assign io_r_valid  = r_valid_q;
  assign io_r_rdata  = rdata_q;
  assign io_r_rresp  = rresp_q;
  assign io_r_last   = 1'b1;
  assign io_aw_ready = aw_ready_q;
  assign io_w_ready  = w_ready_q;
  assign io_b_valid  = b_valid_q;
  assign io_b_bresp  = bresp_q;

endmodule

// File: tb/tb_ysyx_22050550_mmio_axi_slave.sv
// tb/tb_ysyx_22050550_mmio_axi_slave.sv - directed bench for the MMIO AXI responder
module tb_ysyx_22050550_mmio_axi_slave;

  localparam logic [63:0] BASE = 64'ha000_0000;
  localparam int          LIM  = 50;
`ifdef MMIO_RESP_CHECK_EN
  localparam logic [1:0]  MISS_RESP = 2'b11;
`else
  localparam logic [1:0]  MISS_RESP = 2'b00;
`endif

  logic        clock = 1'b0, reset = 1'b1;
  logic        io_ar_valid = 1'b0, io_ar_ready;
  logic [63:0] io_ar_addr = '0;
  logic [7:0]  io_ar_len = '0;
  logic [2:0]  io_ar_size = 3'd3;
  logic [1:0]  io_ar_burst = 2'b01;
  logic        io_r_valid, io_r_ready = 1'b0, io_r_last;
  logic [63:0] io_r_rdata;
  logic [1:0]  io_r_rresp;
  logic        io_aw_valid = 1'b0, io_aw_ready;
  logic [63:0] io_aw_addr = '0;
  logic [7:0]  io_aw_len = '0;
  logic [2:0]  io_aw_size = 3'd3;
  logic [1:0]  io_aw_burst = 2'b01;
  logic        io_w_valid = 1'b0, io_w_ready, io_w_last = 1'b1;
  logic [63:0] io_w_data = '0;
  logic [7:0]  io_w_strb = '0;
  logic        io_b_valid, io_b_ready = 1'b0;
  logic [1:0]  io_b_bresp;

  int n_cmp = 0;
  int n_fail = 0;

  ysyx_22050550_mmio_axi_slave dut (
    .clock(clock), .reset(reset),
    .io_ar_valid(io_ar_valid), .io_ar_ready(io_ar_ready), .io_ar_addr(io_ar_addr),
    .io_ar_len(io_ar_len), .io_ar_size(io_ar_size), .io_ar_burst(io_ar_burst),
    .io_r_valid(io_r_valid), .io_r_ready(io_r_ready), .io_r_rdata(io_r_rdata),
    .io_r_rresp(io_r_rresp), .io_r_last(io_r_last),
    .io_aw_valid(io_aw_valid), .io_aw_ready(io_aw_ready), .io_aw_addr(io_aw_addr),
    .io_aw_len(io_aw_len), .io_aw_size(io_aw_size), .io_aw_burst(io_aw_burst),
    .io_w_valid(io_w_valid), .io_w_ready(io_w_ready), .io_w_data(io_w_data),
    .io_w_strb(io_w_strb), .io_w_last(io_w_last),
    .io_b_valid(io_b_valid), .io_b_ready(io_b_ready), .io_b_bresp(io_b_bresp)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [1:0] resp);
    int t = 0;
    io_aw_addr = a; io_aw_valid = 1'b1;
    io_w_data = d; io_w_strb = s; io_w_valid = 1'b1; io_b_ready = 1'b1;
    while (!io_aw_ready && t < LIM) begin step(); t++; end
    step(); io_aw_valid = 1'b0;
    while (!io_w_ready && t < LIM) begin step(); t++; end
    step(); io_w_valid = 1'b0;
    while (!io_b_valid && t < LIM) begin step(); t++; end
    resp = io_b_bresp;
    step(); io_b_ready = 1'b0;
    n_cmp++;
    if (t >= LIM) begin n_fail++; $display("FAIL wr_timeout addr=%h waited=%0d limit=%0d", a, t, LIM); end
  endtask

  task automatic axi_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] resp);
    int t = 0;
    io_ar_addr = a; io_ar_valid = 1'b1;
    while (!io_ar_ready && t < LIM) begin step(); t++; end
    step(); io_ar_valid = 1'b0; io_r_ready = 1'b1;
    while (!io_r_valid && t < LIM) begin step(); t++; end
    d = io_r_rdata; resp = io_r_rresp;
    step(); io_r_ready = 1'b0;
    n_cmp++;
    if (t >= LIM) begin n_fail++; $display("FAIL rd_timeout addr=%h waited=%0d limit=%0d", a, t, LIM); end
  endtask

  task automatic test_reset();
    n_cmp++; if (io_ar_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ar_ready got=%b exp=1", io_ar_ready); end
    n_cmp++; if (io_aw_ready !== 1'b1) begin n_fail++; $display("FAIL rst_aw_ready got=%b exp=1", io_aw_ready); end
    n_cmp++; if ({io_r_valid, io_w_ready, io_b_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rst_valids got=%b exp=000", {io_r_valid, io_w_ready, io_b_valid}); end
    n_cmp++; if ({io_r_rdata, io_r_rresp, io_b_bresp} !== 68'd0) begin
      n_fail++; $display("FAIL rst_data got=%h exp=0", {io_r_rdata, io_r_rresp, io_b_bresp}); end
  endtask

  task automatic test_read_latency();
    io_ar_addr = BASE + 64'h8; io_ar_valid = 1'b1;
    step(); io_ar_valid = 1'b0;
    n_cmp++; if (io_r_valid !== 1'b0) begin n_fail++; $display("FAIL lat_rvalid_c1 got=%b exp=0", io_r_valid); end
    step();
    n_cmp++; if (io_r_valid !== 1'b1) begin n_fail++; $display("FAIL lat_rvalid_c2 got=%b exp=1", io_r_valid); end
    n_cmp++; if (io_r_rdata !== 64'd0) begin n_fail++; $display("FAIL lat_rdata got=%h exp=0", io_r_rdata); end
    n_cmp++; if (io_r_rresp !== 2'b00) begin n_fail++; $display("FAIL lat_rresp got=%b exp=00", io_r_rresp); end
    io_r_ready = 1'b1; step(); io_r_ready = 1'b0;
    n_cmp++; if ({io_r_valid, io_ar_ready} !== 2'b01) begin
      n_fail++; $display("FAIL lat_after_hs got=%b exp=01", {io_r_valid, io_ar_ready}); end
  endtask

  task automatic test_strobe_write();
    logic [63:0] d; logic [1:0] r;
    axi_write(BASE + 64'h10, 64'h1122334455667788, 8'h0F, r);
    n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL strb_bresp got=%b exp=00", r); end
    axi_read(BASE + 64'h10, d, r);
    n_cmp++; if (d !== 64'h0000000055667788) begin n_fail++; $display("FAIL strb_rdata got=%h exp=0000000055667788", d); end
    n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL strb_rresp got=%b exp=00", r); end
    axi_write(BASE + 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, r);
    n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL strb0_bresp got=%b exp=00", r); end
    axi_read(BASE + 64'h17, d, r);
    n_cmp++; if (d !== 64'h0000000055667788) begin n_fail++; $display("FAIL strb0_rdata got=%h exp=0000000055667788", d); end
  endtask

  task automatic test_r_backpressure();
    logic [1:0] r; int t = 0;
    axi_write(BASE + 64'h18, 64'hDEADBEEF0BADF00D, 8'hFF, r);
    io_ar_addr = BASE + 64'h18; io_ar_valid = 1'b1; io_r_ready = 1'b0;
    step();
    io_ar_addr = BASE + 64'h8;
    while (!io_r_valid && t < LIM) begin step(); t++; end
    n_cmp++; if (t >= LIM) begin n_fail++; $display("FAIL bp_timeout waited=%0d limit=%0d", t, LIM); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (io_r_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rvalid cyc=%0d got=%b exp=1", i, io_r_valid); end
      n_cmp++; if (io_r_rdata !== 64'hDEADBEEF0BADF00D) begin
        n_fail++; $display("FAIL bp_rdata cyc=%0d got=%h exp=deadbeef0badf00d", i, io_r_rdata); end
      n_cmp++; if (io_ar_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ar_ready cyc=%0d got=%b exp=0", i, io_ar_ready); end
      step();
    end
    io_r_ready = 1'b1; step(); io_r_ready = 1'b0;
    n_cmp++; if ({io_ar_ready, io_r_valid} !== 2'b10) begin
      n_fail++; $display("FAIL bp_post_hs got=%b exp=10", {io_ar_ready, io_r_valid}); end
    step(); io_ar_valid = 1'b0;
    n_cmp++; if (io_ar_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_ar_accept got=%b exp=0", io_ar_ready); end
    io_r_ready = 1'b1; t = 0;
    while (!io_r_valid && t < LIM) begin step(); t++; end
    n_cmp++; if (io_r_rdata !== 64'd0 || t >= LIM) begin
      n_fail++; $display("FAIL bp_next_rdata got=%h exp=0 waited=%0d", io_r_rdata, t); end
    step(); io_r_ready = 1'b0;
  endtask

  task automatic test_w_before_aw();
    logic [63:0] d; logic [1:0] r; int nb = 0;
    io_w_data = 64'hA5A500001234_5678; io_w_strb = 8'hFF; io_w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (io_w_ready !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready cyc=%0d got=%b exp=0", i, io_w_ready); end
    end
    io_aw_addr = BASE + 64'h20; io_aw_valid = 1'b1;
    step(); io_aw_valid = 1'b0;
    n_cmp++; if (io_w_ready !== 1'b1) begin n_fail++; $display("FAIL wfirst_wready_after_aw got=%b exp=1", io_w_ready); end
    step(); io_w_valid = 1'b0; io_b_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (io_b_valid) nb++;
      step();
    end
    io_b_ready = 1'b0;
    n_cmp++; if (nb !== 1) begin n_fail++; $display("FAIL wfirst_b_count got=%0d exp=1", nb); end
    axi_read(BASE + 64'h20, d, r);
    n_cmp++; if (d !== 64'hA5A5000012345678) begin n_fail++; $display("FAIL wfirst_rdata got=%h exp=a5a5000012345678", d); end
  endtask

  task automatic test_same_reg();
    logic [63:0] d; logic [1:0] r;
    axi_write(BASE + 64'h28, 64'h1111111111111111, 8'hFF, r);
    io_ar_addr = BASE + 64'h28; io_ar_valid = 1'b1;
    io_aw_addr = BASE + 64'h28; io_aw_valid = 1'b1;
    io_w_data = 64'h2222222222222222; io_w_strb = 8'hFF; io_w_valid = 1'b1;
    step(); io_ar_valid = 1'b0; io_aw_valid = 1'b0;
    step(); io_w_valid = 1'b0;
    n_cmp++; if ({io_r_valid, io_b_valid} !== 2'b11) begin
      n_fail++; $display("FAIL same_valids got=%b exp=11", {io_r_valid, io_b_valid}); end
    n_cmp++; if (io_r_rdata !== 64'h1111111111111111) begin
      n_fail++; $display("FAIL same_old_rdata got=%h exp=1111111111111111", io_r_rdata); end
    io_r_ready = 1'b1; io_b_ready = 1'b1;
    step(); io_r_ready = 1'b0; io_b_ready = 1'b0;
    axi_read(BASE + 64'h28, d, r);
    n_cmp++; if (d !== 64'h2222222222222222) begin n_fail++; $display("FAIL same_new_rdata got=%h exp=2222222222222222", d); end
  endtask

  task automatic test_miss();
    logic [63:0] d; logic [1:0] r;
    axi_write(BASE + 64'h80, 64'hFFFFFFFFFFFFFFFF, 8'hFF, r);
    n_cmp++; if (r !== MISS_RESP) begin n_fail++; $display("FAIL miss_bresp got=%b exp=%b", r, MISS_RESP); end
    axi_read(BASE + 64'h80, d, r);
    n_cmp++; if (d !== 64'd0) begin n_fail++; $display("FAIL miss_rdata got=%h exp=0", d); end
    n_cmp++; if (r !== MISS_RESP) begin n_fail++; $display("FAIL miss_rresp got=%b exp=%b", r, MISS_RESP); end
    axi_read(BASE, d, r);
    n_cmp++; if (d !== 64'd0) begin n_fail++; $display("FAIL miss_reg0 got=%h exp=0", d); end
    axi_read(BASE + 64'h78, d, r);
    n_cmp++; if (d !== 64'd0) begin n_fail++; $display("FAIL miss_reg15 got=%h exp=0", d); end
    axi_read(BASE - 64'h8, d, r);
    n_cmp++; if (r !== MISS_RESP || d !== 64'd0) begin
      n_fail++; $display("FAIL miss_below got=%h/%b exp=0/%b", d, r, MISS_RESP); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic [1:0] r;
    io_ar_addr = BASE + 64'h10; io_ar_valid = 1'b1;
    io_aw_addr = BASE + 64'h10; io_aw_valid = 1'b1;
    step(); io_ar_valid = 1'b0; io_aw_valid = 1'b0;
    step();
    n_cmp++; if ({io_r_valid, io_w_ready} !== 2'b11) begin
      n_fail++; $display("FAIL rmid_pre got=%b exp=11", {io_r_valid, io_w_ready}); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({io_r_valid, io_w_ready, io_b_valid, io_ar_ready, io_aw_ready} !== 5'b00011) begin
      n_fail++; $display("FAIL rmid_async got=%b exp=00011", {io_r_valid, io_w_ready, io_b_valid, io_ar_ready, io_aw_ready}); end
    step(); reset = 1'b0; step();
    axi_read(BASE + 64'h10, d, r);
    n_cmp++; if (d !== 64'd0) begin n_fail++; $display("FAIL rmid_cleared got=%h exp=0", d); end
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    step();
    test_reset();
    test_read_latency();
    test_strobe_write();
    test_r_backpressure();
    test_w_before_aw();
    test_same_reg();
    test_miss();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
